// File: rtl/conv_window_ctrl_if.sv
// Pixel-stream control bundle between the sensor/RAW2GRAY front end and the
// 3x3 window sequencer. The master side drives frame/pixel/kernel requests.
interface conv_window_ctrl_if #(
    parameter int CNT_W = 11
);
    logic             iFRAME_START;
    logic             iDVAL;
    logic [1:0]       iKSEL;
    logic [1:0]       oKSEL;
    logic             oLB_EN;
    logic             oWIN_VALID;
    logic [CNT_W-1:0] oWIN_X;
    logic [CNT_W-1:0] oWIN_Y;
    logic             oBUSY;
    logic             oFRAME_DONE;
    logic             oFRAME_ERR;

    modport master (
        output iFRAME_START, iDVAL, iKSEL,
        input  oKSEL, oLB_EN, oWIN_VALID, oWIN_X, oWIN_Y, oBUSY, oFRAME_DONE, oFRAME_ERR
    );

    modport slave (
        input  iFRAME_START, iDVAL, iKSEL,
        output oKSEL, oLB_EN, oWIN_VALID, oWIN_X, oWIN_Y, oBUSY, oFRAME_DONE, oFRAME_ERR
    );
endinterface

// File: rtl/conv_window_ctrl.sv
// Frame/line sequencer for the 3x3 Sobel datapath: tracks pixel position, gates the
// line buffers, and emits latency-aligned window-valid strobes with centre coordinates.
module conv_window_ctrl #(
    parameter int IMG_W    = 1280,
    parameter int IMG_H    = 960,
    parameter int PIPE_LAT = 2,
    parameter int CNT_W    = 11
) (
    input logic               iCLK,
    input logic               iRST,
    conv_window_ctrl_if.slave bus
);
    localparam int DRAIN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [CNT_W-1:0]   LAST_COL   = CNT_W'(IMG_W - 1);
    localparam logic [CNT_W-1:0]   LAST_ROW   = CNT_W'(IMG_H - 1);
    localparam logic [DRAIN_W-1:0] LAST_DRAIN = DRAIN_W'(PIPE_LAT - 1);

    typedef enum logic [1:0] {IDLE, PRIME, RUN, DRAIN} stateT;

    stateT              state;
    logic [CNT_W-1:0]   col;
    logic [CNT_W-1:0]   row;
    logic [DRAIN_W-1:0] drainCnt;
    logic [1:0]         kSel;
    logic               frameDone;
    logic               frameErr;

    logic               counting;
    logic               accept;
    logic               startErr;
    logic               rawValid;
    logic [1:0]         kSelMapped;

    logic               pipeValid [PIPE_LAT];
    logic [CNT_W-1:0]   pipeX     [PIPE_LAT];
    logic [CNT_W-1:0]   pipeY     [PIPE_LAT];

    // A start pulse always accepts a coincident pixel as (0,0), even from DRAIN.
    always_comb begin
        counting   = (state == PRIME) || (state == RUN);
        accept     = !iRST && bus.iDVAL && (counting || bus.iFRAME_START);
        startErr   = bus.iFRAME_START && (state != IDLE);
        rawValid   = accept && !bus.iFRAME_START && (row >= CNT_W'(2)) && (col >= CNT_W'(2));
        kSelMapped = (bus.iKSEL == 2'd3) ? 2'd2 : bus.iKSEL;
    end

    // DRAIN lasts PIPE_LAT clocks so its final clock lines up with the last window result.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state     <= IDLE;
            col       <= '0;
            row       <= '0;
            drainCnt  <= '0;
            kSel      <= 2'd0;
            frameDone <= 1'b0;
            frameErr  <= 1'b0;
        end else begin
            frameDone <= 1'b0;
            frameErr  <= startErr;
            if (bus.iFRAME_START) begin
                state    <= PRIME;
                kSel     <= kSelMapped;
                row      <= '0;
                drainCnt <= '0;
                col      <= bus.iDVAL ? CNT_W'(1) : '0;
            end else begin
                unique case (state)
                    IDLE: ;
                    PRIME, RUN: begin
                        if (bus.iDVAL) begin
                            if (col == LAST_COL) begin
                                col <= '0;
                                if (row == LAST_ROW) begin
                                    state     <= DRAIN;
                                    row       <= '0;
                                    drainCnt  <= '0;
                                    frameDone <= (LAST_DRAIN == '0);
                                end else begin
                                    row <= row + CNT_W'(1);
                                    if (row == CNT_W'(1)) begin
                                        state <= RUN;
                                    end
                                end
                            end else begin
                                col <= col + CNT_W'(1);
                            end
                        end
                    end
                    DRAIN: begin
                        if (drainCnt == LAST_DRAIN) begin
                            state <= IDLE;
                        end else begin
                            drainCnt  <= drainCnt + DRAIN_W'(1);
                            frameDone <= ((drainCnt + DRAIN_W'(1)) == LAST_DRAIN);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Coordinates only move alongside a valid bit so the outputs hold between strobes.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                pipeValid[i] <= 1'b0;
                pipeX[i]     <= '0;
                pipeY[i]     <= '0;
            end
        end else begin
            pipeValid[0] <= rawValid;
            if (rawValid) begin
                pipeX[0] <= col - CNT_W'(1);
                pipeY[0] <= row - CNT_W'(1);
            end
            for (int i = 1; i < PIPE_LAT; i++) begin
                pipeValid[i] <= startErr ? 1'b0 : pipeValid[i-1];
                if (pipeValid[i-1] && !startErr) begin
                    pipeX[i] <= pipeX[i-1];
                    pipeY[i] <= pipeY[i-1];
                end
            end
        end
    end

    assign bus.oKSEL       = kSel;
    assign bus.oLB_EN      = accept;
    assign bus.oWIN_VALID  = pipeValid[PIPE_LAT-1];
    assign bus.oWIN_X      = pipeX[PIPE_LAT-1];
    assign bus.oWIN_Y      = pipeY[PIPE_LAT-1];
    assign bus.oBUSY       = (state != IDLE);
    assign bus.oFRAME_DONE = frameDone;
    assign bus.oFRAME_ERR  = frameErr;
endmodule

// File: tb/tb_conv_window_ctrl.sv
// Bench for conv_window_ctrl on a 4x3 frame: directed vector table, hand-built
// corner sequences, and random traffic against a pixel-index reference model.
module tb_conv_window_ctrl;
    localparam int IMG_W    = 4;
    localparam int IMG_H    = 3;
    localparam int PIPE_LAT = 2;
    localparam int CNT_W    = 11;

    typedef struct {
        bit         start;
        bit         dval;
        logic [1:0] ksel;
        int         lbEn;
        int         valid;
        int         x;
        int         y;
        int         done;
        int         busy;
        int         kselOut;
    } vecT;

    logic iCLK = 1'b0;
    logic iRST;

    always #5 iCLK = ~iCLK;

    conv_window_ctrl_if #(.CNT_W(CNT_W)) bus ();

    conv_window_ctrl #(
        .IMG_W   (IMG_W),
        .IMG_H   (IMG_H),
        .PIPE_LAT(PIPE_LAT),
        .CNT_W   (CNT_W)
    ) dut (
        .iCLK(iCLK),
        .iRST(iRST),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    bit mActive = 1'b0;
    int mPix = 0;
    int mDrainEnd = -1;
    int mKsel = 0;
    int mLastX = 0;
    int mLastY = 0;
    bit expV[int];
    int expX[int];
    int expY[int];
    bit expDone[int];
    bit expErr[int];

    int lastLbEn;
    int seenValid, seenDone, seenErr, lastDoneCyc;
    int obsX[$];
    int obsY[$];
    int obsCyc[$];
    int pixCyc[16];
    vecT vecs[$];

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, actual, expected);
        end
    endtask

    // Model tracks the frame as a flat pixel index; results are scheduled by cycle number.
    task automatic applyStimulus(input bit rst, input bit start, input bit dval, input logic [1:0] ksel);
        bit busyNow;
        int col;
        int row;
        iRST             = rst;
        bus.iFRAME_START = start;
        bus.iDVAL        = dval;
        bus.iKSEL        = ksel;
        #1;
        busyNow  = mActive || (cyc <= mDrainEnd);
        lastLbEn = int'(bus.oLB_EN);
        checkOutput("lbEn", lastLbEn, int'(!rst && dval && (mActive || start)));
        if (rst) begin
            mActive = 1'b0; mPix = 0; mDrainEnd = -1; mKsel = 0; mLastX = 0; mLastY = 0;
            expV.delete(); expX.delete(); expY.delete(); expDone.delete(); expErr.delete();
        end else if (start) begin
            if (busyNow) begin
                for (int c = cyc + 1; c <= cyc + PIPE_LAT; c++) begin
                    expV.delete(c); expX.delete(c); expY.delete(c); expDone.delete(c);
                end
                expErr[cyc + 1] = 1'b1;
            end
            mKsel = (ksel == 2'd3) ? 2 : int'(ksel);
            mActive = 1'b1;
            mPix = dval ? 1 : 0;
            mDrainEnd = -1;
        end else if (mActive && dval) begin
            col = mPix % IMG_W;
            row = mPix / IMG_W;
            if (row >= 2 && col >= 2) begin
                expV[cyc + PIPE_LAT] = 1'b1;
                expX[cyc + PIPE_LAT] = col - 1;
                expY[cyc + PIPE_LAT] = row - 1;
            end
            mPix++;
            if (mPix == IMG_W * IMG_H) begin
                mActive = 1'b0;
                mDrainEnd = cyc + PIPE_LAT;
                expDone[cyc + PIPE_LAT] = 1'b1;
            end
        end
        @(posedge iCLK);
        #1;
        cyc++;
        if (expV.exists(cyc)) begin
            mLastX = expX[cyc];
            mLastY = expY[cyc];
        end
        checkOutput("winValid", int'(bus.oWIN_VALID), int'(expV.exists(cyc)));
        checkOutput("winX", int'(bus.oWIN_X), mLastX);
        checkOutput("winY", int'(bus.oWIN_Y), mLastY);
        checkOutput("frameDone", int'(bus.oFRAME_DONE), int'(expDone.exists(cyc)));
        checkOutput("frameErr", int'(bus.oFRAME_ERR), int'(expErr.exists(cyc)));
        checkOutput("busy", int'(bus.oBUSY), int'(mActive || (cyc <= mDrainEnd)));
        checkOutput("ksel", int'(bus.oKSEL), mKsel);
        if (bus.oWIN_VALID) begin
            seenValid++;
            obsX.push_back(int'(bus.oWIN_X));
            obsY.push_back(int'(bus.oWIN_Y));
            obsCyc.push_back(cyc);
        end
        if (bus.oFRAME_DONE) begin
            seenDone++;
            lastDoneCyc = cyc;
        end
        if (bus.oFRAME_ERR) seenErr++;
    endtask

    task automatic addVec(input bit s, input bit d, input logic [1:0] k, input int lb, input int v,
                          input int x, input int y, input int dn, input int bz, input int ko);
        vecT e;
        e.start = s; e.dval = d; e.ksel = k; e.lbEn = lb; e.valid = v;
        e.x = x; e.y = y; e.done = dn; e.busy = bz; e.kselOut = ko;
        vecs.push_back(e);
    endtask

    task automatic clearSeen();
        seenValid = 0; seenDone = 0; seenErr = 0; lastDoneCyc = -1;
        obsX.delete(); obsY.delete(); obsCyc.delete();
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "Valid"}, int'(bus.oWIN_VALID), 0);
        checkOutput({tag, "X"}, int'(bus.oWIN_X), 0);
        checkOutput({tag, "Y"}, int'(bus.oWIN_Y), 0);
        checkOutput({tag, "Busy"}, int'(bus.oBUSY), 0);
        checkOutput({tag, "Ksel"}, int'(bus.oKSEL), 0);
        checkOutput({tag, "Done"}, int'(bus.oFRAME_DONE), 0);
        checkOutput({tag, "Err"}, int'(bus.oFRAME_ERR), 0);
        checkOutput({tag, "LbEn"}, int'(bus.oLB_EN), 0);
    endtask

    initial begin
        iRST = 1'b1;
        bus.iFRAME_START = 1'b0;
        bus.iDVAL = 1'b0;
        bus.iKSEL = 2'd0;
        clearSeen();

        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        iRST = 1'b0;
        #1;
        checkAllZero("reset");

        // Back-to-back frame, kernel 1; request changes mid-frame and in DRAIN are ignored.
        addVec(1, 0, 2'd1, 0, 0, 0, 0, 0, 1, 1);
        for (int p = 1; p <= 12; p++) begin
            addVec(0, 1, (p < 5) ? 2'd1 : 2'd0, 1, (p == 12) ? 1 : 0,
                   (p == 12) ? 1 : 0, (p == 12) ? 1 : 0, 0, 1, 1);
        end
        addVec(0, 1, 2'd2, 0, 1, 2, 1, 1, 1, 1);
        addVec(0, 1, 2'd2, 0, 0, 2, 1, 0, 0, 1);
        clearSeen();
        foreach (vecs[i]) begin
            applyStimulus(0, vecs[i].start, vecs[i].dval, vecs[i].ksel);
            checkOutput("vecLbEn", lastLbEn, vecs[i].lbEn);
            checkOutput("vecValid", int'(bus.oWIN_VALID), vecs[i].valid);
            checkOutput("vecX", int'(bus.oWIN_X), vecs[i].x);
            checkOutput("vecY", int'(bus.oWIN_Y), vecs[i].y);
            checkOutput("vecDone", int'(bus.oFRAME_DONE), vecs[i].done);
            checkOutput("vecBusy", int'(bus.oBUSY), vecs[i].busy);
            checkOutput("vecKsel", int'(bus.oKSEL), vecs[i].kselOut);
        end
        checkOutput("vecValidCount", seenValid, 2);

        // Toggling iDVAL with kernel 3 requested, then 0 mid-frame.
        clearSeen();
        applyStimulus(0, 1, 0, 3);
        begin
            int pixNo = 0;
            for (int i = 0; i < 24; i++) begin
                if (i % 2 == 0) begin
                    pixNo++;
                    pixCyc[pixNo] = cyc;
                end
                applyStimulus(0, 0, (i % 2 == 0), 2'd0);
                checkOutput("toggleKsel", int'(bus.oKSEL), 2);
            end
        end
        repeat (3) applyStimulus(0, 0, 0, 0);
        checkOutput("toggleCount", seenValid, 2);
        checkOutput("toggleX0", (obsX.size() > 0) ? obsX[0] : -1, 1);
        checkOutput("toggleY0", (obsY.size() > 0) ? obsY[0] : -1, 1);
        checkOutput("toggleX1", (obsX.size() > 1) ? obsX[1] : -1, 2);
        checkOutput("toggleY1", (obsY.size() > 1) ? obsY[1] : -1, 1);
        checkOutput("toggleLat0", (obsCyc.size() > 0) ? obsCyc[0] - pixCyc[11] : -1, 2);
        checkOutput("toggleLat1", (obsCyc.size() > 1) ? obsCyc[1] - pixCyc[12] : -1, 2);
        checkOutput("toggleDone", seenDone, 1);
        checkOutput("toggleDoneAlign", lastDoneCyc, (obsCyc.size() > 1) ? obsCyc[1] : -1);

        // Restart after pixel 9, then a full replacement frame.
        clearSeen();
        applyStimulus(0, 1, 0, 0);
        repeat (9) applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 1, 0, 1);
        checkOutput("restartErrPulse", int'(bus.oFRAME_ERR), 1);
        checkOutput("abortedValids", seenValid, 0);
        repeat (12) applyStimulus(0, 0, 1, 1);
        repeat (3) applyStimulus(0, 0, 0, 1);
        checkOutput("restartErrCount", seenErr, 1);
        checkOutput("restartValids", seenValid, 2);
        checkOutput("restartDone", seenDone, 1);

        // Restart with a window result in flight and a coincident pixel (0,0).
        clearSeen();
        applyStimulus(0, 1, 0, 0);
        repeat (11) applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 1, 1, 2);
        repeat (11) applyStimulus(0, 0, 1, 0);
        repeat (3) applyStimulus(0, 0, 0, 0);
        checkOutput("flushErrCount", seenErr, 1);
        checkOutput("flushValids", seenValid, 2);
        checkOutput("flushFirstX", (obsX.size() > 0) ? obsX[0] : -1, 1);
        checkOutput("flushDone", seenDone, 1);

        // Reset mid-frame aborts silently; pixels without a start are not taken.
        clearSeen();
        applyStimulus(0, 1, 0, 1);
        repeat (10) applyStimulus(0, 0, 1, 1);
        applyStimulus(1, 0, 0, 0);
        iRST = 1'b0;
        #1;
        checkAllZero("midReset");
        repeat (4) begin
            applyStimulus(0, 0, 1, 1);
            checkOutput("noStartLbEn", lastLbEn, 0);
        end
        checkOutput("midResetDone", seenDone, 0);
        checkOutput("midResetErr", seenErr, 0);

        repeat (3000) begin
            applyStimulus($urandom_range(0, 999) < 5,
                          $urandom_range(0, 49) == 0,
                          $urandom_range(0, 9) < 7,
                          2'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
